// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle CPU main controller: state
// encoding, OpCode/Funct values, ALUOp codes and mux-select encodings.
// ALUOp codes here are also consumed by the ALU-control decoder.
package mc_ctrl_pkg;

    typedef enum logic [4:0] {
        S_IF, S_ID, S_EX_R, S_WB_R, S_EX_I, S_WB_I,
        S_MEM_ADDR, S_MEM_RD, S_WB_LW, S_MEM_WR,
        S_BR, S_JMP, S_JAL, S_JR, S_JALR, S_LUI, S_TRAP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_BEQ   = 4'd1;
    localparam logic [3:0] ALU_RTYPE = 4'd2;
    localparam logic [3:0] ALU_ADDIU = 4'd3;
    localparam logic [3:0] ALU_ANDI  = 4'd4;
    localparam logic [3:0] ALU_SLTI  = 4'd5;
    localparam logic [3:0] ALU_SLTIU = 4'd6;

    localparam logic [1:0] DST_RT = 2'd0;
    localparam logic [1:0] DST_RD = 2'd1;
    localparam logic [1:0] DST_RA = 2'd2;

    localparam logic [1:0] MTR_ALU = 2'd0;
    localparam logic [1:0] MTR_MDR = 2'd1;
    localparam logic [1:0] MTR_PC  = 2'd2;
    localparam logic [1:0] MTR_LUI = 2'd3;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_A     = 2'd1;
    localparam logic [1:0] SRCA_SHAMT = 2'd2;

    localparam logic [1:0] SRCB_B      = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] PCS_ALU    = 2'd0;
    localparam logic [1:0] PCS_ALUOUT = 2'd1;
    localparam logic [1:0] PCS_JUMP   = 2'd2;
    localparam logic [1:0] PCS_REG    = 2'd3;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_op;
        logic [3:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    // R-type functions the datapath implements; anything else is
    // treated as illegal when trapping is enabled.
    function automatic logic funct_ok(input logic [5:0] f);
        case (f)
            6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
            6'h08, 6'h09, 6'h20, 6'h21, 6'h22, 6'h23,
            6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b:
                funct_ok = 1'b1;
            default: funct_ok = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational Moore output decode: {state, OpCode, Funct} -> control
// bundle. Ports: state, OpCode, Funct in; ctrl (ctrl_t) out.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] OpCode,
    input  logic [5:0] Funct,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_IF: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.pc_write  = 1'b1;
            end
            S_ID: begin
                // Branch target precomputed into ALUOut.
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.ext_op    = 1'b1;
            end
            S_EX_R: begin
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_RTYPE;
                ctrl.alu_src_a = (Funct == FN_SLL || Funct == FN_SRL ||
                                  Funct == FN_SRA) ? SRCA_SHAMT : SRCA_A;
            end
            S_WB_R: begin
                ctrl.reg_dst   = DST_RD;
                ctrl.reg_write = 1'b1;
            end
            S_EX_I: begin
                ctrl.alu_src_a = SRCA_A;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.ext_op    = (OpCode != OP_ANDI);
                case (OpCode)
                    OP_ANDI:  ctrl.alu_op = ALU_ANDI;
                    OP_SLTI:  ctrl.alu_op = ALU_SLTI;
                    OP_SLTIU: ctrl.alu_op = ALU_SLTIU;
                    default:  ctrl.alu_op = ALU_ADDIU;
                endcase
            end
            S_WB_I: ctrl.reg_write = 1'b1;
            S_MEM_ADDR: begin
                ctrl.alu_src_a = SRCA_A;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.ext_op    = 1'b1;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_WB_LW: begin
                ctrl.mem_to_reg = MTR_MDR;
                ctrl.reg_write  = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_BR: begin
                ctrl.alu_src_a     = SRCA_A;
                ctrl.alu_op        = ALU_BEQ;
                ctrl.pc_source     = PCS_ALUOUT;
                ctrl.pc_write_cond = 1'b1;
            end
            S_JMP: begin
                ctrl.pc_source = PCS_JUMP;
                ctrl.pc_write  = 1'b1;
            end
            S_JAL: begin
                ctrl.pc_source  = PCS_JUMP;
                ctrl.pc_write   = 1'b1;
                ctrl.reg_dst    = DST_RA;
                ctrl.mem_to_reg = MTR_PC;
                ctrl.reg_write  = 1'b1;
            end
            S_JR: begin
                ctrl.pc_source = PCS_REG;
                ctrl.pc_write  = 1'b1;
            end
            S_JALR: begin
                ctrl.pc_source  = PCS_REG;
                ctrl.pc_write   = 1'b1;
                ctrl.reg_dst    = DST_RD;
                ctrl.mem_to_reg = MTR_PC;
                ctrl.reg_write  = 1'b1;
            end
            S_LUI: begin
                ctrl.mem_to_reg = MTR_LUI;
                ctrl.reg_write  = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle CPU: state register, dispatch,
// retired-instruction counter. Ports: clk, reset (sync, high), OpCode,
// Funct, Zero in; datapath enables/selects, ALUOp, InstrRetired out.
// MC_CTRL_ILLEGAL_TRAP_EN: undecoded instructions enter TRAP and drive
// IllegalInst; otherwise they retire as NOPs.
module multicycle_controller
    import mc_ctrl_pkg::*;
#(
    parameter int INSTR_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [5:0]             OpCode,
    input  logic [5:0]             Funct,
    input  logic                   Zero,
    output logic                   PCWrite,
    output logic                   PCWriteCond,
    output logic                   IorD,
    output logic                   MemRead,
    output logic                   MemWrite,
    output logic                   IRWrite,
    output logic                   RegWrite,
    output logic [1:0]             RegDst,
    output logic [1:0]             MemtoReg,
    output logic [1:0]             ALUSrcA,
    output logic [1:0]             ALUSrcB,
    output logic                   ExtOp,
    output logic [3:0]             ALUOp,
    output logic [1:0]             PCSource,
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    output logic                   IllegalInst,
`endif
    output logic [INSTR_CNT_W-1:0] InstrRetired
);

    state_t state, state_next;
    logic   retire;
    ctrl_t  ctrl, ctrl_q;

    // Zero qualifies PCWriteCond inside the datapath, not here.
    logic unused_zero;
    assign unused_zero = Zero;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IF;
            InstrRetired <= '0;
        end else begin
            state <= state_next;
            if (retire)
                InstrRetired <= InstrRetired + INSTR_CNT_W'(1);
        end
    end

    always_comb begin
        state_next = state;
        retire     = 1'b0;
        case (state)
            S_IF: state_next = S_ID;
            S_ID: begin
                case (OpCode)
                    OP_RTYPE: begin
                        if (Funct == FN_JR)
                            state_next = S_JR;
                        else if (Funct == FN_JALR)
                            state_next = S_JALR;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                        else if (!funct_ok(Funct))
                            state_next = S_TRAP;
`endif
                        else
                            state_next = S_EX_R;
                    end
                    OP_LW, OP_SW: state_next = S_MEM_ADDR;
                    OP_BEQ:       state_next = S_BR;
                    OP_J:         state_next = S_JMP;
                    OP_JAL:       state_next = S_JAL;
                    OP_LUI:       state_next = S_LUI;
                    OP_ADDI, OP_ADDIU, OP_ANDI,
                    OP_SLTI, OP_SLTIU:
                                  state_next = S_EX_I;
                    default: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                        state_next = S_TRAP;
`else
                        state_next = S_IF;
                        retire     = 1'b1;
`endif
                    end
                endcase
            end
            S_EX_R:     state_next = S_WB_R;
            S_EX_I:     state_next = S_WB_I;
            S_MEM_ADDR: state_next = (OpCode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   state_next = S_WB_LW;
            S_WB_R, S_WB_I, S_WB_LW, S_MEM_WR, S_BR,
            S_JMP, S_JAL, S_JR, S_JALR, S_LUI: begin
                state_next = S_IF;
                retire     = 1'b1;
            end
            S_TRAP:  state_next = S_TRAP;
            default: state_next = S_IF;
        endcase
    end

    mc_ctrl_decode u_decode (
        .state  (state),
        .OpCode (OpCode),
        .Funct  (Funct),
        .ctrl   (ctrl)
    );

    // Outputs are forced quiet for the whole reset window, including the
    // first cycle when the state register may still hold a stale state.
    assign ctrl_q = reset ? '0 : ctrl;

    assign PCWrite     = ctrl_q.pc_write;
    assign PCWriteCond = ctrl_q.pc_write_cond;
    assign IorD        = ctrl_q.iord;
    assign MemRead     = ctrl_q.mem_read;
    assign MemWrite    = ctrl_q.mem_write;
    assign IRWrite     = ctrl_q.ir_write;
    assign RegWrite    = ctrl_q.reg_write;
    assign RegDst      = ctrl_q.reg_dst;
    assign MemtoReg    = ctrl_q.mem_to_reg;
    assign ALUSrcA     = ctrl_q.alu_src_a;
    assign ALUSrcB     = ctrl_q.alu_src_b;
    assign ExtOp       = ctrl_q.ext_op;
    assign ALUOp       = ctrl_q.alu_op;
    assign PCSource    = ctrl_q.pc_source;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    assign IllegalInst = !reset && (state == S_TRAP);
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed cases plus
// random instruction stream against a per-instruction cycle-table model.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  OpCode = '0;
    logic [5:0]  Funct = '0;
    logic        Zero = 1'b0;
    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite;
    logic        IRWrite, RegWrite, ExtOp;
    logic [1:0]  RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource;
    logic [3:0]  ALUOp;
    logic [31:0] InstrRetired;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    logic        IllegalInst;
`endif

    int checks = 0;
    int errors = 0;
    int model_cnt = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.INSTR_CNT_W(32)) dut (
        .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct),
        .Zero(Zero), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ExtOp(ExtOp), .ALUOp(ALUOp), .PCSource(PCSource),
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        .IllegalInst(IllegalInst),
`endif
        .InstrRetired(InstrRetired)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] obs();
        obs = {10'b0, PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
               IRWrite, RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB,
               ExtOp, ALUOp, PCSource};
    endfunction

    localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4;
    localparam int K_J = 5, K_JAL = 6, K_JR = 7, K_JALR = 8;
    localparam int K_LUI = 9, K_NOP = 10;

    function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00: kind_of = (fn == 6'h08) ? K_JR :
                             (fn == 6'h09) ? K_JALR : K_R;
            6'h23: kind_of = K_LW;
            6'h2b: kind_of = K_SW;
            6'h04: kind_of = K_BEQ;
            6'h02: kind_of = K_J;
            6'h03: kind_of = K_JAL;
            6'h0f: kind_of = K_LUI;
            6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c: kind_of = K_I;
            default: kind_of = K_NOP;
        endcase
    endfunction

    function automatic int latency(input int kd);
        case (kd)
            K_LW: latency = 5;
            K_R, K_I, K_SW: latency = 4;
            K_NOP: latency = 2;
            default: latency = 3;
        endcase
    endfunction

    // Expected outputs of cycle k (0 = fetch) of one instruction.
    function automatic logic [31:0] expv(input logic [5:0] op,
                                         input logic [5:0] fn, input int k);
        logic pcw, pcwc, iord, mr, mw, irw, rw, ext;
        logic [1:0] rd, mtr, sa, sb, pcs;
        logic [3:0] aop;
        int kd;
        {pcw, pcwc, iord, mr, mw, irw, rw, ext} = '0;
        {rd, mtr, sa, sb, pcs} = '0;
        aop = 4'd0;
        kd = kind_of(op, fn);
        if (k == 0) begin
            mr = 1; irw = 1; sb = 2'd1; pcw = 1;
        end else if (k == 1) begin
            sb = 2'd3; ext = 1;
        end else begin
            case (kd)
                K_R: if (k == 2) begin
                    sb = 0; aop = 4'd2;
                    sa = (fn == 6'h00 || fn == 6'h02 || fn == 6'h03) ? 2'd2 : 2'd1;
                end else begin
                    rd = 2'd1; rw = 1;
                end
                K_I: if (k == 2) begin
                    sa = 2'd1; sb = 2'd2; ext = (op != 6'h0c);
                    aop = (op == 6'h0c) ? 4'd4 : (op == 6'h0a) ? 4'd5 :
                          (op == 6'h0b) ? 4'd6 : 4'd3;
                end else rw = 1;
                K_LW, K_SW: if (k == 2) begin
                    sa = 2'd1; sb = 2'd2; ext = 1;
                end else if (k == 3) begin
                    iord = 1;
                    if (kd == K_LW) mr = 1; else mw = 1;
                end else begin
                    mtr = 2'd1; rw = 1;
                end
                K_BEQ: begin sa = 2'd1; aop = 4'd1; pcs = 2'd1; pcwc = 1; end
                K_J:   begin pcs = 2'd2; pcw = 1; end
                K_JAL: begin pcs = 2'd2; pcw = 1; rd = 2'd2; mtr = 2'd2; rw = 1; end
                K_JR:  begin pcs = 2'd3; pcw = 1; end
                K_JALR: begin pcs = 2'd3; pcw = 1; rd = 2'd1; mtr = 2'd2; rw = 1; end
                K_LUI: begin mtr = 2'd3; rw = 1; end
                default: ;
            endcase
        end
        expv = {10'b0, pcw, pcwc, iord, mr, mw, irw, rw, rd, mtr, sa, sb,
                ext, aop, pcs};
    endfunction

    // Entered and left at posedge+1 with the DUT in fetch.
    task automatic run_instr(input string tag, input logic [5:0] op,
                             input logic [5:0] fn, input logic z);
        int lat;
        OpCode = op; Funct = fn; Zero = z;
        lat = latency(kind_of(op, fn));
        for (int k = 0; k < lat; k++) begin
            #1 check($sformatf("%s.c%0d", tag, k), obs(), expv(op, fn, k));
            @(posedge clk); #1;
        end
        model_cnt++;
        check({tag, ".cnt"}, InstrRetired, model_cnt);
    endtask

    logic [5:0] ops [0:13] = '{6'h00, 6'h00, 6'h23, 6'h2b, 6'h04, 6'h02,
                               6'h03, 6'h0f, 6'h08, 6'h09, 6'h0a, 6'h0b,
                               6'h0c, 6'h3f};
    logic [5:0] fns [0:11] = '{6'h00, 6'h02, 6'h03, 6'h20, 6'h21, 6'h22,
                               6'h24, 6'h25, 6'h2a, 6'h2b, 6'h08, 6'h09};

    initial begin
        repeat (3) @(posedge clk);
        #1 check("rst.ctl", obs(), 32'd0);
        check("rst.cnt", InstrRetired, 32'd0);
        reset = 1'b0;

        run_instr("add", 6'h00, 6'h20, 1'b0);
        run_instr("sll", 6'h00, 6'h00, 1'b0);
        run_instr("lw", 6'h23, 6'h15, 1'b0);
        run_instr("sw", 6'h2b, 6'h08, 1'b0);
        run_instr("beq1", 6'h04, 6'h00, 1'b1);
        run_instr("beq0", 6'h04, 6'h00, 1'b0);
        run_instr("jal", 6'h03, 6'h00, 1'b0);
        run_instr("jr", 6'h00, 6'h08, 1'b0);
        run_instr("andi", 6'h0c, 6'h00, 1'b0);

        // Reset held three cycles while lw sits in its memory-read cycle.
        OpCode = 6'h23; Funct = 6'h00;
        for (int k = 0; k < 3; k++) begin
            #1 check($sformatf("lwr.c%0d", k), obs(), expv(6'h23, 6'h00, k));
            @(posedge clk); #1;
        end
        #1 check("lwr.mem", obs(), expv(6'h23, 6'h00, 3));
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1 check($sformatf("lwr.rst%0d", k), obs(), 32'd0);
            @(posedge clk); #1;
        end
        reset = 1'b0;
        model_cnt = 0;
        #1 check("lwr.if", obs(), expv(6'h23, 6'h00, 0));
        check("lwr.cnt", InstrRetired, 32'd0);
        @(posedge clk); #1;
        for (int k = 1; k < 5; k++) begin
            #1 check($sformatf("lwr2.c%0d", k), obs(), expv(6'h23, 6'h00, k));
            @(posedge clk); #1;
        end
        model_cnt++;
        check("lwr2.cnt", InstrRetired, model_cnt);

        for (int n = 0; n < 80; n++) begin
            logic [5:0] op, fn;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            op = ops[$urandom_range(0, 12)];
`else
            op = ops[$urandom_range(0, 13)];
`endif
            fn = (op == 6'h00) ? fns[$urandom_range(0, 11)] : 6'($urandom);
            run_instr($sformatf("rnd%0d", n), op, fn, 1'($urandom));
        end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        OpCode = 6'h3f; Funct = 6'h00;
        #1 check("trap.if", obs(), expv(6'h3f, 6'h00, 0));
        @(posedge clk); #1;
        #1 check("trap.id", obs(), expv(6'h3f, 6'h00, 1));
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            #1 check($sformatf("trap.ctl%0d", k), obs(), 32'd0);
            check($sformatf("trap.ill%0d", k), {31'b0, IllegalInst}, 32'd1);
            check($sformatf("trap.cnt%0d", k), InstrRetired, model_cnt);
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1 check("trap.clr", {31'b0, IllegalInst}, 32'd0);
        check("trap.rcnt", InstrRetired, 32'd0);
`else
        run_instr("ill", 6'h3f, 6'h00, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
